// File: rtl/uart_stim_gen.sv
// uart_stim_gen: continuous UART frame generator with an incrementing payload, for RX self-test.
// Define UART_STIM_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_stim_gen #(
   parameter int unsigned CLK_FREQ    = 10000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned GAP_BITS    = 10,
   parameter int unsigned START_VALUE = 32'h42
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] load_value,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frame_count,
   output logic [DATA_BITS-1:0] cur_value
);
   localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
   } state_t;

`ifdef UART_STIM_PARITY_EN
   localparam state_t AFTER_DATA = S_PARITY;
`else
   localparam state_t AFTER_DATA = S_STOP;
`endif

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic                   r_tx;
   logic                   w_tx_nxt;
   logic                   r_busy;
   logic                   r_frame_done;
   logic                   w_done_nxt;
   logic                   w_bit_end;
   logic                   w_stop_end;
   logic                   w_load_ok;
   logic [15:0]            r_frame_count;
   logic [DATA_BITS-1:0]   r_cur_value;
   logic [DATA_BITS-1:0]   w_data_shift;

   // Next state, bit/counter bookkeeping and look-ahead values for the registered outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = '0;
      w_tx_nxt     = 1'b1;
      w_bit_end    = (r_cnt == CNT_LAST);
      w_stop_end   = (r_state == S_STOP) && w_bit_end && (r_idx == STOP_LAST);
      w_load_ok    = load && ((r_state == S_IDLE) || (r_state == S_GAP));

      case (r_state)
         S_IDLE: begin
            w_idx_nxt = '0;
            if (enable) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == DATA_LAST) begin
                  w_state_nxt = AFTER_DATA;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_idx_nxt   = '0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_idx == STOP_LAST) begin
                  w_idx_nxt = '0;
                  if (!enable)          w_state_nxt = S_IDLE;
                  else if (GAP_BITS > 0) w_state_nxt = S_GAP;
                  else                  w_state_nxt = S_START;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         S_GAP: begin
            // Dropping enable abandons the rest of the gap straight away
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (w_bit_end) begin
               if (r_idx == GAP_LAST) begin
                  w_state_nxt = S_START;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase

      if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE) || w_bit_end)
         w_cnt_nxt = '0;
      else
         w_cnt_nxt = r_cnt + CNT_W'(1);

      w_data_shift = r_cur_value >> w_idx_nxt;
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_data_shift[0];
         S_PARITY: w_tx_nxt = ^r_cur_value;
         default:  w_tx_nxt = 1'b1;
      endcase

      // frame_done is raised for the final cycle of the last stop bit
      w_done_nxt = (w_state_nxt == S_STOP) && (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == STOP_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // End-of-frame increment takes priority over a coincident load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx          <= 1'b1;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_cur_value   <= DATA_BITS'(START_VALUE);
      end else begin
         r_tx         <= w_tx_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_frame_done <= w_done_nxt;
         if (w_stop_end) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_cur_value   <= r_cur_value + DATA_BITS'(1);
         end else if (w_load_ok) begin
            r_cur_value <= load_value;
         end
      end
   end

   assign tx          = r_tx;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign cur_value   = r_cur_value;

endmodule

// File: tb/tb_uart_stim_gen.sv
// Self-checking bench for uart_stim_gen: decodes tx like a UART receiver and compares against
// payload/count/timing expectations derived from the frame format.
module tb_uart_stim_gen;
   localparam int CLK_FREQ  = 10000000;
   localparam int BAUD_RATE = 115200;
   localparam int DB        = 8;
   localparam int SB        = 1;
   localparam int GAP       = 10;
   localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_STIM_PARITY_EN
   localparam int PB        = 1;
`else
   localparam int PB        = 0;
`endif
   localparam int NBITS     = 1 + DB + PB + SB;
   localparam int FRAME_LEN = NBITS * DIV;
   localparam int PERIOD    = FRAME_LEN + GAP * DIV;
   localparam logic [DB-1:0] START_V = 8'h42;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          enable     = 1'b0;
   logic          load       = 1'b0;
   logic [DB-1:0] load_value = '0;
   logic          tx;
   logic          busy;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic [DB-1:0] cur_value;

   int            n_tests   = 0;
   int            n_fail    = 0;
   int            cyc       = 0;
   logic [15:0]   exp_count = '0;
   logic [DB-1:0] model_v   = START_V;

   uart_stim_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .DATA_BITS  (DB),
      .STOP_BITS  (SB),
      .GAP_BITS   (GAP),
      .START_VALUE(32'h42)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_count(frame_count),
      .cur_value  (cur_value)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   // Waits (bounded) for the first negedge with the line low.
   task automatic wait_start(input int budget, output int t, output bit ok);
      ok = 1'b0;
      t  = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            t  = cyc;
         end
      end
   endtask

   // Receiver: k=0 is the current negedge (first start-bit cycle); samples mid-bit, optionally
   // drops enable / pulses load at given offsets, and returns post-frame values at k=FRAME_LEN.
   task automatic rx_frame(input int drop_k, input int load_k, input logic [DB-1:0] lv,
                           output logic [DB-1:0] data, output logic par, output bit framing_ok,
                           output int done_k, output bit busy_ok, output logic [15:0] cnt_after,
                           output logic [DB-1:0] cur_after, output logic busy_after);
      framing_ok = 1'b1;
      busy_ok    = 1'b1;
      done_k     = -1;
      data       = '0;
      par        = 1'b0;
      cnt_after  = '0;
      cur_after  = '0;
      busy_after = 1'b0;
      for (int k = 0; k <= FRAME_LEN; k++) begin
         if (k > 0) @(negedge clk);
         if (k == drop_k) enable = 1'b0;
         load = (k == load_k);
         if (k == load_k) load_value = lv;
         if (frame_done === 1'b1) done_k = (done_k < 0) ? k : -2;
         if (k == FRAME_LEN) begin
            cnt_after  = frame_count;
            cur_after  = cur_value;
            busy_after = busy;
         end else begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (k % DIV == DIV / 2) begin
               if (k / DIV == 0) begin
                  if (tx !== 1'b0) framing_ok = 1'b0;
               end else if (k / DIV <= DB) begin
                  data = {tx, data[DB-1:1]};
               end else if (PB == 1 && k / DIV == DB + 1) begin
                  par = tx;
               end else if (tx !== 1'b1) begin
                  framing_ok = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
      n_tests++; if (cur_value !== START_V) begin n_fail++; $display("FAIL reset_value: got %h expected %h", cur_value, START_V); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b expected 1/0", tx, busy); end
   endtask

   task automatic test_stream();
      logic [DB-1:0] d, cur_a, nv;
      logic [15:0]   cnt_a;
      logic          p, bz_a;
      bit            fr, bz, ok;
      int            dk, t0, t1;
      @(negedge clk); enable = 1'b1;
      @(negedge clk); t0 = cyc;
      n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL start_latency: tx=%b expected 0 one cycle after enable", tx); end
      for (int f = 0; f < 2; f++) begin
         if (f > 0) begin
            wait_start(PERIOD + 4, t1, ok);
            n_tests++; if (!ok || t1 - t0 != PERIOD) begin n_fail++; $display("FAIL frame_period: got %0d cycles expected %0d", t1 - t0, PERIOD); end
            t0 = t1;
         end
         rx_frame(-1, -1, '0, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
         exp_count++;
         nv = model_v + 1'b1;
         n_tests++; if (d !== model_v) begin n_fail++; $display("FAIL stream_data: got %h expected %h", d, model_v); end
         n_tests++; if (!fr || !bz) begin n_fail++; $display("FAIL stream_framing: framing_ok=%0d busy_ok=%0d expected 1/1", fr, bz); end
         n_tests++; if (dk != FRAME_LEN - 1) begin n_fail++; $display("FAIL stream_frame_done: at cycle %0d expected %0d", dk, FRAME_LEN - 1); end
         n_tests++; if (cnt_a !== exp_count) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", cnt_a, exp_count); end
         n_tests++; if (cur_a !== nv) begin n_fail++; $display("FAIL stream_next_value: got %h expected %h", cur_a, nv); end
`ifdef UART_STIM_PARITY_EN
         n_tests++; if (p !== ^model_v) begin n_fail++; $display("FAIL stream_parity: got %b expected %b", p, ^model_v); end
`endif
         model_v = nv;
      end
      enable = 1'b0;
      @(negedge clk);
      n_tests++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL gap_abort: busy=%b tx=%b expected 0/1", busy, tx); end
   endtask

   task automatic test_load_wrap();
      logic [DB-1:0] exp_tab [4];
      logic [DB-1:0] d, cur_a;
      logic [15:0]   cnt_a;
      logic          p, bz_a;
      bit            fr, bz, ok;
      int            dk, t;
      exp_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      @(negedge clk); load = 1'b1; load_value = 8'hFE;
      @(negedge clk); load = 1'b0;
      n_tests++; if (cur_value !== 8'hFE) begin n_fail++; $display("FAIL idle_load: got %h expected fe", cur_value); end
      enable = 1'b1;
      for (int f = 0; f < 4; f++) begin
         wait_start(PERIOD + 4, t, ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_start: no start bit seen, got none expected frame %0d", f); end
         rx_frame(-1, -1, '0, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
         exp_count++;
         n_tests++; if (d !== exp_tab[f] || !fr) begin n_fail++; $display("FAIL wrap_data: got %h (framing %0d) expected %h", d, fr, exp_tab[f]); end
         n_tests++; if (cnt_a !== exp_count) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", cnt_a, exp_count); end
`ifdef UART_STIM_PARITY_EN
         n_tests++; if (p !== ^exp_tab[f]) begin n_fail++; $display("FAIL wrap_parity: got %b expected %b", p, ^exp_tab[f]); end
`endif
      end
      model_v = 8'h02;
      enable  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random_load();
      logic [DB-1:0] lv, d, cur_a, expv;
      logic [15:0]   cnt_a;
      logic          p, bz_a;
      bit            fr, bz, ok;
      int            dk, t, n;
      for (int r = 0; r < 3; r++) begin
         lv = DB'($urandom);
         n  = int'($urandom_range(1, 2));
         @(negedge clk); load = 1'b1; load_value = lv;
         @(negedge clk); load = 1'b0; enable = 1'b1;
         for (int f = 0; f < n; f++) begin
            expv = DB'((int'(lv) + f) % (1 << DB));
            wait_start(PERIOD + 4, t, ok);
            rx_frame(-1, -1, '0, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
            exp_count++;
            n_tests++; if (!ok || d !== expv || !fr) begin n_fail++; $display("FAIL rand_data: got %h (start %0d framing %0d) expected %h", d, ok, fr, expv); end
            n_tests++; if (cnt_a !== exp_count) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", cnt_a, exp_count); end
         end
         model_v = DB'((int'(lv) + n) % (1 << DB));
         enable  = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_enable_drop();
      logic [DB-1:0] d, cur_a;
      logic [15:0]   cnt_a;
      logic          p, bz_a;
      bit            fr, bz, ok, quiet;
      int            dk, t;
      @(negedge clk); enable = 1'b1;
      wait_start(8, t, ok);
      rx_frame(4 * DIV + DIV / 2, -1, '0, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
      exp_count++;
      n_tests++; if (!ok || d !== model_v || !fr) begin n_fail++; $display("FAIL drop_frame: got %h (start %0d framing %0d) expected %h", d, ok, fr, model_v); end
      n_tests++; if (dk != FRAME_LEN - 1 || !bz) begin n_fail++; $display("FAIL drop_done: done at %0d busy_ok %0d expected %0d/1", dk, bz, FRAME_LEN - 1); end
      n_tests++; if (bz_a !== 1'b0) begin n_fail++; $display("FAIL drop_busy_fall: got %b expected 0 one cycle after frame_done", bz_a); end
      n_tests++; if (cnt_a !== exp_count) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", cnt_a, exp_count); end
      model_v = model_v + 1'b1;
      quiet = 1'b1;
      repeat (GAP * DIV + 2 * DIV) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      n_tests++; if (!quiet) begin n_fail++; $display("FAIL drop_idle: line activity got 1 expected 0"); end
   endtask

   task automatic test_load_ignore();
      logic [DB-1:0] la, lb, lc, d, cur_a, nv;
      logic [15:0]   cnt_a;
      logic          p, bz_a;
      bit            fr, bz, ok;
      int            dk, t;
      la = DB'($urandom); if (la == model_v) la = ~model_v;
      @(negedge clk); enable = 1'b1;
      wait_start(8, t, ok);
      rx_frame(-1, 3 * DIV, la, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
      exp_count++;
      nv = model_v + 1'b1;
      n_tests++; if (d !== model_v || cur_a !== nv) begin n_fail++; $display("FAIL data_load_ignored: data %h next %h expected %h/%h", d, cur_a, model_v, nv); end
      model_v = nv;
      lb = DB'($urandom); if (lb == model_v + 1'b1) lb = ~lb;
      wait_start(PERIOD + 4, t, ok);
      rx_frame(-1, FRAME_LEN - 1, lb, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
      exp_count++;
      nv = model_v + 1'b1;
      n_tests++; if (d !== model_v || cur_a !== nv) begin n_fail++; $display("FAIL stop_load_dropped: data %h next %h expected %h/%h", d, cur_a, model_v, nv); end
      n_tests++; if (cnt_a !== exp_count) begin n_fail++; $display("FAIL ignore_count: got %0d expected %0d", cnt_a, exp_count); end
      lc = DB'($urandom);
      repeat (2 * DIV) @(negedge clk);
      load = 1'b1; load_value = lc;
      @(negedge clk); load = 1'b0;
      n_tests++; if (cur_value !== lc) begin n_fail++; $display("FAIL gap_load: got %h expected %h", cur_value, lc); end
      wait_start(PERIOD + 4, t, ok);
      rx_frame(-1, -1, '0, d, p, fr, dk, bz, cnt_a, cur_a, bz_a);
      exp_count++;
      n_tests++; if (!ok || d !== lc || !fr) begin n_fail++; $display("FAIL gap_load_frame: got %h expected %h", d, lc); end
      model_v = lc + 1'b1;
      enable  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stop();
      int  pos [2];
      int  t;
      bit  ok;
      pos = '{DIV / 2, (1 + DB + PB) * DIV + DIV / 2};
      for (int r = 0; r < 2; r++) begin
         @(negedge clk); enable = 1'b1;
         wait_start(8, t, ok);
         repeat (pos[r]) @(negedge clk);
         n_tests++; if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
         rst = 1'b1;
         #1;
         n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: tx=%b busy=%b expected 1/0 before any edge", tx, busy); end
         enable = 1'b0;
         @(negedge clk); rst = 1'b0;
         @(negedge clk);
         exp_count = '0;
         model_v   = START_V;
         n_tests++; if (cur_value !== START_V || frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_restore: value %h count %0d expected %h/0", cur_value, frame_count, START_V); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_load_wrap();
      test_random_load();
      test_enable_drop();
      test_load_ignore();
      test_reset_mid_stop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
